// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 32x32 register file with a one-cycle staged write path and combinational reads.
// Optional read bypass from the write stage is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_wb (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB,
    output logic        wr_pending
);

    logic [31:0] regs [1:31];
    logic        stg_valid;
    logic [4:0]  stg_idx;
    logic [31:0] stg_data;
    logic [31:0] wr_sel;
    logic [31:0] arr_a;
    logic [31:0] arr_b;

    // Writes to r0 never enter the stage, so a valid stage always names r1..r31.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stg_valid <= 1'b0;
            stg_idx   <= 5'd0;
            stg_data  <= 32'h0;
        end else begin
            stg_valid <= ctrl_writeEnable && (ctrl_writeReg != 5'd0);
            stg_idx   <= ctrl_writeReg;
            stg_data  <= data_writeReg;
        end
    end

    always_comb begin
        wr_sel = 32'h0;
        for (int i = 0; i < 32; i++) begin
            wr_sel[i] = stg_valid && (stg_idx == 5'(i));
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 1; i < 32; i++) begin
            if (!reset_n) begin
                regs[i] <= 32'h0;
            end else if (wr_sel[i]) begin
                regs[i] <= stg_data;
            end
        end
    end

    always_comb begin
        arr_a = 32'h0;
        arr_b = 32'h0;
        for (int i = 1; i < 32; i++) begin
            if (ctrl_readRegA == 5'(i)) arr_a = regs[i];
            if (ctrl_readRegB == 5'(i)) arr_b = regs[i];
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Forward only from the stage; data_writeReg itself is never forwarded.
    always_comb begin
        data_readRegA = arr_a;
        data_readRegB = arr_b;
        if (stg_valid && (stg_idx == ctrl_readRegA)) data_readRegA = stg_data;
        if (stg_valid && (stg_idx == ctrl_readRegB)) data_readRegB = stg_data;
    end
`else
    always_comb begin
        data_readRegA = arr_a;
        data_readRegB = arr_b;
    end
`endif

    assign wr_pending = stg_valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - table-driven scoreboard bench for reg_file_wb.
module tb_reg_file_wb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        wr_pending;

    reg_file_wb dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .wr_pending       (wr_pending)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  widx;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ea_byp;
        logic [31:0] eb_byp;
        logic        ep;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ep;
    } exp_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] widx, input logic [31:0] wdata,
                         input logic [4:0] ra, input logic [4:0] rb);
        ctrl_writeEnable = we;
        ctrl_writeReg    = widx;
        data_writeReg    = wdata;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        exp_t e;
        vecs[0]  = '{1'b1, 5'd3,  32'h12345678, 5'd3,  5'd0,  32'h0, 32'h0, 32'h12345678, 32'h0, 1'b1};
        vecs[1]  = '{1'b0, 5'd3,  32'h0,        5'd3,  5'd3,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd3,  32'h0, 32'h12345678, 32'hA5A5A5A5, 32'h12345678, 1'b1};
        vecs[5]  = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vecs[6]  = '{1'b1, 5'd9,  32'h1,        5'd9,  5'd10, 32'h0, 32'h0, 32'h1, 32'h0, 1'b1};
        vecs[7]  = '{1'b1, 5'd9,  32'h2,        5'd9,  5'd10, 32'h1, 32'h0, 32'h2, 32'h0, 1'b1};
        vecs[8]  = '{1'b1, 5'd10, 32'h3,        5'd9,  5'd10, 32'h2, 32'h0, 32'h2, 32'h3, 1'b1};
        vecs[9]  = '{1'b0, 5'd10, 32'h0,        5'd9,  5'd10, 32'h2, 32'h3, 32'h2, 32'h3, 1'b0};
        vecs[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{1'b0, 5'd31, 32'h0,        5'd31, 5'd0,  32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[12] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd7,  32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 1'b1};
        vecs[13] = '{1'b0, 5'd5,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0};

        reset_n = 1'b0;
        drive(1'b1, 5'd4, 32'h11111111, 5'd4, 5'd0);
        @(negedge clock);
        step();
        step();
        chk("reset_pending", {31'h0, wr_pending}, 32'h0);
        chk("reset_read_a", data_readRegA, 32'h0);
        chk("reset_read_b", data_readRegB, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].we, vecs[i].widx, vecs[i].wdata, vecs[i].ra, vecs[i].rb);
            e.row = i;
`ifdef REG_FILE_BYPASS_EN
            e.ea = vecs[i].ea_byp;
            e.eb = vecs[i].eb_byp;
`else
            e.ea = vecs[i].ea;
            e.eb = vecs[i].eb;
`endif
            e.ep = vecs[i].ep;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            chk($sformatf("vec%0d_read_a", e.row), data_readRegA, e.ea);
            chk($sformatf("vec%0d_read_b", e.row), data_readRegB, e.eb);
            chk($sformatf("vec%0d_pending", e.row), {31'h0, wr_pending}, {31'h0, e.ep});
        end

        // r5 holds DEADBEEF here; two reset edges must clear it.
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        step();
        step();
        reset_n = 1'b1;
        chk("rst2_r5", data_readRegA, 32'h0);
        chk("rst2_r9", data_readRegB, 32'h0);
        chk("rst2_pending", {31'h0, wr_pending}, 32'h0);

        // Capture-cycle data must not appear on the read port before the edge.
        drive(1'b1, 5'd11, 32'hCAFEF00D, 5'd11, 5'd11);
        #1;
        chk("no_fwd_precapture", data_readRegA, 32'h0);
        step();
        chk("r11_pending", {31'h0, wr_pending}, 32'h1);
        drive(1'b0, 5'd0, 32'h0, 5'd11, 5'd11);
        step();
        chk("r11_commit_a", data_readRegA, 32'hCAFEF00D);
        chk("r11_commit_b", data_readRegB, 32'hCAFEF00D);

        // Reset on the commit edge of a staged write, with a new write also requested.
        drive(1'b1, 5'd12, 32'h55, 5'd12, 5'd13);
        step();
        chk("r12_staged", {31'h0, wr_pending}, 32'h1);
        reset_n = 1'b0;
        drive(1'b1, 5'd13, 32'h66, 5'd12, 5'd13);
        step();
        chk("r12_rst_a", data_readRegA, 32'h0);
        chk("r12_rst_b", data_readRegB, 32'h0);
        chk("r12_rst_pending", {31'h0, wr_pending}, 32'h0);
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd13);
        step();
        chk("r12_after_a", data_readRegA, 32'h0);
        chk("r12_after_b", data_readRegB, 32'h0);
        chk("r12_after_pending", {31'h0, wr_pending}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
